pixel_pair_serializer: RTL

//  Downstream of the pixel memory handler. Accepts two parallel 8-bit pixels per clk while read=1 and

---
 rtl/pixel_pair_serializer_pkg.sv | 19 +
 rtl/pixel_pair_serializer_if.sv | 22 ++
 rtl/pixel_pair_serializer_fifo.sv | 57 +++++
 rtl/pixel_pair_serializer.sv | 89 ++++++++
 4 files changed

// File: rtl/pixel_pair_serializer_pkg.sv
// Shared types for the pixel pair serializer.
// Default widths and the stored pixel entry layout.
package pixel_pkg;

    localparam int PIX_DATA_W = 8;
    localparam int PIX_ROW_W  = 4;

    typedef struct packed {
        logic                  sof;
        logic [PIX_ROW_W-1:0]  row;
        logic [PIX_DATA_W-1:0] data;
    } pix_entry_t;

    // Width of an occupancy count able to hold 0..depth
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pixel_pair_serializer_if.sv
// Output pixel stream: valid/ready with row and start-of-frame tags.
// master drives pixels, slave returns ready.
interface pixel_pair_serializer_if #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 4
);
    logic [DATA_W-1:0] pix_out;
    logic [ROW_W-1:0]  pix_row;
    logic              pix_sof;
    logic              pix_valid;
    logic              out_ready;

    modport master (
        output pix_out, pix_row, pix_sof, pix_valid,
        input  out_ready
    );

    modport slave (
        input  pix_out, pix_row, pix_sof, pix_valid,
        output out_ready
    );
endinterface

// File: rtl/pixel_pair_serializer_fifo.sv
// Dual-write / single-read FIFO, first-word-fall-through.
// Flush clears it but a same-cycle push still lands at entries 0 and 1.
module pix_fifo_2w1r #(
    parameter type entry_t = logic [12:0],
    parameter int  DEPTH   = 8,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LVL_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  entry_t           d0,
    input  entry_t           d1,
    input  logic             pop,
    output entry_t           head,
    output logic [LVL_W-1:0] level
);
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ix0;
    logic [PTR_W-1:0] wr_ix1;
    logic             pop_ok;
    logic [LVL_W-1:0] push_amt;

    assign wr_ix0   = flush ? '0 : wr_ptr;
    assign wr_ix1   = wr_ix0 + PTR_W'(1);
    assign pop_ok   = pop && (level != '0) && !flush;
    assign push_amt = push ? LVL_W'(2) : '0;
    assign head     = mem[rd_ptr];

    // Storage write: both pair entries land in consecutive slots
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ix0] <= d0;
            mem[wr_ix1] <= d1;
        end
    end

    // Pointer and occupancy tracking; flush restarts from slot 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= push ? PTR_W'(2) : '0;
            rd_ptr <= '0;
            level  <= push_amt;
        end else begin
            wr_ptr <= wr_ptr + (push ? PTR_W'(2) : '0);
            rd_ptr <= rd_ptr + (pop_ok ? PTR_W'(1) : '0);
            level  <= level + push_amt - (pop_ok ? LVL_W'(1) : '0);
        end
    end
endmodule

// File: rtl/pixel_pair_serializer.sv
// Pixel pair serializer: accepts two pixels per read, emits one per cycle.
// Decides accept/drop, tags start-of-frame, keeps overflow and pixel count.
module pixel_pair_serializer
    import pixel_pkg::*;
#(
    parameter int  DATA_W = PIX_DATA_W,
    parameter int  ROW_W  = PIX_ROW_W,
    parameter int  DEPTH  = 8,
    parameter int  CNT_W  = 16,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              read,
    input  logic [DATA_W-1:0] pixData1,
    input  logic [DATA_W-1:0] pixData2,
    input  logic [ROW_W-1:0]  read_select,
    pixel_pair_serializer_if.master stream,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_pixels
);
    typedef struct packed {
        logic              sof;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t head;
    entry_t d0;
    entry_t d1;
    logic   sof_pending;
    logic   room;
    logic   push;
    logic   drop;
    logic   pop;
    logic   valid;

    // Free space is judged on the start-of-cycle level; a flush frees all
    assign room  = fifo_level <= LVL_W'(DEPTH - 2);
    assign push  = read && (frame_start || room);
    assign drop  = read && !frame_start && !room;
    assign valid = fifo_level != '0;
    assign pop   = valid && stream.out_ready && !frame_start;

    assign d0 = '{sof: frame_start || sof_pending, row: read_select, data: pixData1};
    assign d1 = '{sof: 1'b0, row: read_select, data: pixData2};

    pix_fifo_2w1r #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .flush (frame_start),
        .push  (push),
        .d0    (d0),
        .d1    (d1),
        .pop   (pop),
        .head  (head),
        .level (fifo_level)
    );

    // Head is forced to zero when empty so stale storage never shows
    always_comb begin
        stream.pix_valid = valid;
        stream.pix_out   = valid ? head.data : '0;
        stream.pix_row   = valid ? head.row  : '0;
        stream.pix_sof   = valid && head.sof;
    end

    // Frame bookkeeping: sof tag, sticky overflow, popped-pixel count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sof_pending  <= 1'b1;
            overflow     <= 1'b0;
            frame_pixels <= '0;
        end else if (frame_start) begin
            sof_pending  <= !read;
            overflow     <= 1'b0;
            frame_pixels <= '0;
        end else begin
            if (push) sof_pending <= 1'b0;
            if (drop) overflow <= 1'b1;
            if (pop)  frame_pixels <= frame_pixels + CNT_W'(1);
        end
    end
endmodule
